rifl_tx_framer: RTL and testbench

Transmit-side framing stage that sits directly upstream of the GT wrapper's 128-bit `tx_data` input, in the `tx_clk` (usrclk2) domain. It accepts 126-bit user payload over a valid/ready handshake, prepends a 2-bit sync header, and substitutes idle words whenever no payload is offered. It also forces a keep-alive control word at a fixed period and scrambles the 126-bit payload field before the word is presented to the transceiver.

---
 rtl/rifl_tx_framer_if.sv | 9 +
 rtl/rifl_tx_framer.sv | 109 ++++++++++
 tb/tb_rifl_tx_framer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rifl_tx_framer_if.sv
// rtl/rifl_tx_framer_if.sv - payload handshake bundle between user logic and the RIFL TX framer
interface rifl_tx_framer_if;
    logic [125:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;

    modport master (output s_axis_tdata, output s_axis_tvalid, input  s_axis_tready);
    modport slave  (input  s_axis_tdata, input  s_axis_tvalid, output s_axis_tready);
endinterface

// File: rtl/rifl_tx_framer.sv
// rtl/rifl_tx_framer.sv - RIFL TX framer: sync header, idle fill, keep-alive insertion, optional scrambler (RIFL_TX_SCRAMBLE_EN)
module rifl_tx_framer #(
    parameter int          KEEPALIVE_PERIOD = 1024,
    parameter logic [7:0]  IDLE_CODE        = 8'h1E,
    parameter logic [7:0]  KA_CODE          = 8'h78
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_good,
    rifl_tx_framer_if.slave       s_axis,
    output logic [127:0]          tx_data,
    output logic [15:0]           ka_count
);
    localparam logic [1:0]  HDR_DATA = 2'b01;
    localparam logic [1:0]  HDR_CTRL = 2'b10;
    localparam logic [15:0] KA_LAST  = 16'(KEEPALIVE_PERIOD - 1);

    typedef enum logic {LINK_WAIT, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   ka_cnt;
    logic [15:0]   ka_cnt_nxt;
    logic          ka_inc;
    logic          ready;
    logic [1:0]    hdr_nxt;
    logic [125:0]  payload_nxt;
    logic [125:0]  word_payload;

    assign s_axis.s_axis_tready = ready;

    // Next state, word selection and handshake; tready ignores tvalid, and a
    // dropping tx_good takes priority over a pending keep-alive.
    always_comb begin
        state_nxt   = state;
        ka_cnt_nxt  = 16'd0;
        ka_inc      = 1'b0;
        ready       = 1'b0;
        hdr_nxt     = HDR_CTRL;
        payload_nxt = {IDLE_CODE, 118'd0};
        case (state)
            LINK_WAIT: begin
                if (tx_good) state_nxt = RUN;
            end
            RUN: begin
                if (!tx_good) begin
                    state_nxt = LINK_WAIT;
                end else if (ka_cnt == KA_LAST) begin
                    payload_nxt = {KA_CODE, 102'd0, ka_count};
                    ka_inc      = 1'b1;
                end else begin
                    ready      = 1'b1;
                    ka_cnt_nxt = ka_cnt + 16'd1;
                    if (s_axis.s_axis_tvalid) begin
                        hdr_nxt     = HDR_DATA;
                        payload_nxt = s_axis.s_axis_tdata;
                    end
                end
            end
            default: state_nxt = LINK_WAIT;
        endcase
    end

`ifdef RIFL_TX_SCRAMBLE_EN
    // hist[k+58] holds scrambled bit s(k); the low 58 entries are the prior word's history.
    function automatic logic [183:0] scramble(input logic [57:0] st, input logic [125:0] din);
        logic [183:0] hist;
        hist = '0;
        for (int m = 0; m < 58; m++) hist[57-m] = st[m];
        for (int i = 0; i < 126; i++) hist[i+58] = din[i] ^ hist[i+19] ^ hist[i];
        return hist;
    endfunction

    logic [57:0]  scr_state;
    logic [57:0]  scr_nxt;
    logic [183:0] scr_hist;

    // Scramble the selected payload and collect the newest 58 scrambled bits.
    always_comb begin
        scr_hist     = scramble(scr_state, payload_nxt);
        word_payload = scr_hist[183:58];
        scr_nxt      = '0;
        for (int m = 0; m < 58; m++) scr_nxt[m] = scr_hist[183-m];
    end

    // Scrambler advances on every transmitted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scr_state <= '1;
        else        scr_state <= scr_nxt;
    end
`else
    assign word_payload = payload_nxt;
`endif

    // State, keep-alive counters and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LINK_WAIT;
            ka_cnt   <= 16'd0;
            ka_count <= 16'd0;
            tx_data  <= 128'd0;
        end else begin
            state   <= state_nxt;
            ka_cnt  <= ka_cnt_nxt;
            tx_data <= {hdr_nxt, word_payload};
            if (ka_inc) ka_count <= ka_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_rifl_tx_framer.sv
// tb/tb_rifl_tx_framer.sv - self-checking bench for rifl_tx_framer against a behavioural word model
module tb_rifl_tx_framer;
    localparam int P = 8;
    localparam logic [127:0] IDLE_WORD = {2'b10, 8'h1E, 118'd0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_good = 1'b0;
    logic [127:0] tx_data;
    logic [15:0]  ka_count;

    rifl_tx_framer_if bus ();

    rifl_tx_framer #(.KEEPALIVE_PERIOD(P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_good  (tx_good),
        .s_axis   (bus),
        .tx_data  (tx_data),
        .ka_count (ka_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit m_run;
    int m_cyc;
    int m_kas;
`ifdef RIFL_TX_SCRAMBLE_EN
    logic [57:0] ds;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic recover(input logic [125:0] rx, output logic [125:0] plain);
`ifdef RIFL_TX_SCRAMBLE_EN
        for (int i = 0; i < 126; i++) begin
            plain[i] = rx[i] ^ ds[38] ^ ds[57];
            ds = {ds[56:0], rx[i]};
        end
`else
        plain = rx;
`endif
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_cyc = 0;
        m_kas = 0;
`ifdef RIFL_TX_SCRAMBLE_EN
        ds = '1;
`endif
    endtask

    task automatic step(input logic good, input logic valid, input logic [125:0] data, output logic rdy);
        logic [127:0] exp;
        logic [125:0] plain;
        bit ka;
        @(negedge clk);
        tx_good = good;
        bus.s_axis_tvalid = valid;
        bus.s_axis_tdata = data;
        #1;
        ka = m_run && ((m_cyc % P) == P - 1);
        rdy = bus.s_axis_tready;
        check("tready", {127'd0, rdy}, {127'd0, m_run && good && !ka});
        exp = IDLE_WORD;
        if (!m_run) begin
            if (good) begin
                m_run = 1'b1;
                m_cyc = 0;
            end
        end else if (!good) begin
            m_run = 1'b0;
        end else begin
            if (ka) begin
                exp = {2'b10, 8'h78, 102'd0, m_kas[15:0]};
                m_kas++;
            end else if (valid) begin
                exp = {2'b01, data};
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
        recover(tx_data[125:0], plain);
        check("tx_data", {tx_data[127:126], plain}, exp);
        check("ka_count", {112'd0, ka_count}, {112'd0, m_kas[15:0]});
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        tx_good = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx_data", tx_data, 128'd0);
        check("reset_tready", {127'd0, bus.s_axis_tready}, 128'd0);
        check("reset_ka_count", {112'd0, ka_count}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic         rdy;
        logic [125:0] val;
        logic [127:0] r128;
        int           low_q[$];

        model_reset();
        hold_reset();

        // Link down: idles only, tready low even with tvalid high.
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, 126'd5, rdy);
`ifndef RIFL_TX_SCRAMBLE_EN
            if (c == 0) check("first_idle_literal", tx_data, 128'h8780_0000_0000_0000_0000_0000_0000_0000);
`endif
        end

        // Link up, continuous incrementing stream; keep-alives at RUN cycles 7, 15, 23.
        step(1'b1, 1'b1, 126'd0, rdy);
        val = 126'd1;
        for (int c = 0; c < 26; c++) begin
            step(1'b1, 1'b1, val, rdy);
            if (!rdy) low_q.push_back(c);
            else      val = val + 126'd1;
        end
        check("ka_gap_count", 128'(low_q.size()), 128'd3);
        if (low_q.size() == 3) begin
            check("ka_gap_0", 128'(low_q[0]), 128'd7);
            check("ka_gap_1", 128'(low_q[1]), 128'd15);
            check("ka_gap_2", 128'(low_q[2]), 128'd23);
        end
        check("ka_count_literal", {112'd0, ka_count}, 128'd3);

        // 100 random payloads with occasional tvalid gaps.
        for (int c = 0; c < 100; c++) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, ($urandom_range(0, 7) != 0), r128[125:0], rdy);
        end

        // One-cycle tx_good drop: no accept on that cycle or the next; counter restarts.
        step(1'b0, 1'b1, 126'd77, rdy);
        check("drop_rdy0", {127'd0, rdy}, 128'd0);
        step(1'b1, 1'b1, 126'd78, rdy);
        check("drop_rdy1", {127'd0, rdy}, 128'd0);
        low_q.delete();
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, 126'd100 + 126'(c), rdy);
            if (!rdy) low_q.push_back(c);
        end
        check("restart_first_ka", (low_q.size() > 0) ? 128'(low_q[0]) : 128'hFFFF, 128'd7);

        // Asynchronous reset mid-cycle while tvalid is high.
        #1;
        bus.s_axis_tvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_tx_data", tx_data, 128'd0);
        check("async_tready", {127'd0, bus.s_axis_tready}, 128'd0);
        check("async_ka_count", {112'd0, ka_count}, 128'd0);
        hold_reset();
        for (int c = 0; c < 12; c++) step((c > 1), 1'b1, 126'd900 + 126'(c), rdy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
